trace_pipe_tracker: RTL

- Source end of the CPU trace interface.
- Captures each instruction as it leaves decode and carries its trace fields alongside the pipeline through EX, MEM and WB, dropping bubbles and flushed instructions.
- Presents one registered trace record per retired instruction, with the writeback value attached, to the console trace logger.
- Also keeps a retired-instruction counter.

---
 rtl/trace_pipe_tracker.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/trace_pipe_tracker.sv
// Trace source: decodes each instruction leaving ID, carries its trace fields through
// EX/MEM/WB, and emits one registered record per retired instruction.
module trace_pipe_tracker #(
    parameter int XLEN    = 32,
    parameter int COUNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [XLEN-1:0]        id_instruction,
    input  logic                   id_stall,
    input  logic                   flush_ex,
    input  logic                   pipe_stall,
    input  logic                   wb_rd_we,
    input  logic [XLEN-1:0]        wb_rd_value,
    output logic                   trace_valid,
    output logic [XLEN-1:0]        trace_instruction,
    output logic [4:0]             trace_rd,
    output logic [4:0]             trace_rs1,
    output logic [4:0]             trace_rs2,
    output logic signed [11:0]     trace_imm,
    output logic signed [XLEN-1:0] trace_rd_value,
    output logic [COUNT_W-1:0]     trace_count
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [11:0]     imm;
    } slot_t;

    slot_t id_dec;
    slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;

    logic                   tv_q, tv_d;
    logic [XLEN-1:0]        tins_q, tins_d;
    logic [4:0]             trd_q, trd_d;
    logic [4:0]             trs1_q, trs1_d;
    logic [4:0]             trs2_q, trs2_d;
    logic signed [11:0]     timm_q, timm_d;
    logic signed [XLEN-1:0] trdv_q, trdv_d;
    logic [COUNT_W-1:0]     cnt_q, cnt_d;

    always_comb begin
        id_dec       = '0;
        id_dec.instr = id_instruction;
        id_dec.rd    = id_instruction[11:7];
        id_dec.rs1   = id_instruction[19:15];
        id_dec.rs2   = id_instruction[24:20];
        case (id_instruction[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: id_dec.imm = id_instruction[31:20];
            OP_STORE: begin
                id_dec.imm = {id_instruction[31:25], id_instruction[11:7]};
                id_dec.rd  = 5'd0;
            end
            // Branch offset bits [12:1]; bit 0 is always zero and is not carried.
            OP_BRANCH: begin
                id_dec.imm = {id_instruction[31], id_instruction[7],
                              id_instruction[30:25], id_instruction[11:8]};
                id_dec.rd  = 5'd0;
            end
            default: id_dec.imm = 12'd0;
        endcase
    end

    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        tv_d    = 1'b0;
        tins_d  = tins_q;
        trd_d   = trd_q;
        trs1_d  = trs1_q;
        trs2_d  = trs2_q;
        timm_d  = timm_q;
        trdv_d  = trdv_q;
        cnt_d   = cnt_q;
        if (!pipe_stall) begin
            wb_d        = mem_q;
            mem_d       = ex_q;
            mem_d.valid = ex_q.valid & ~flush_ex;
            ex_d        = id_dec;
            ex_d.valid  = id_valid & ~id_stall & ~flush_ex;
            tv_d        = wb_q.valid;
            if (wb_q.valid) begin
                tins_d = wb_q.instr;
                trd_d  = wb_q.rd;
                trs1_d = wb_q.rs1;
                trs2_d = wb_q.rs2;
                timm_d = wb_q.imm;
                trdv_d = (wb_rd_we && wb_q.rd != 5'd0) ? wb_rd_value : '0;
                cnt_d  = cnt_q + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q   <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            tv_q   <= 1'b0;
            tins_q <= '0;
            trd_q  <= '0;
            trs1_q <= '0;
            trs2_q <= '0;
            timm_q <= '0;
            trdv_q <= '0;
            cnt_q  <= '0;
        end else begin
            ex_q   <= ex_d;
            mem_q  <= mem_d;
            wb_q   <= wb_d;
            tv_q   <= tv_d;
            tins_q <= tins_d;
            trd_q  <= trd_d;
            trs1_q <= trs1_d;
            trs2_q <= trs2_d;
            timm_q <= timm_d;
            trdv_q <= trdv_d;
            cnt_q  <= cnt_d;
        end
    end

    assign trace_valid       = tv_q;
    assign trace_instruction = tins_q;
    assign trace_rd          = trd_q;
    assign trace_rs1         = trs1_q;
    assign trace_rs2         = trs2_q;
    assign trace_imm         = timm_q;
    assign trace_rd_value    = trdv_q;
    assign trace_count       = cnt_q;

endmodule
